// File: rtl/shifter_pkg.sv
// Shared types for the sequential shift/rotate unit: operation codes and FSM states.
package shifter_pkg;

  typedef enum logic [2:0] {
    OP_PASS  = 3'b000,
    OP_SHL   = 3'b001,
    OP_SHR   = 3'b010,
    OP_CLR   = 3'b011,
    OP_PASS2 = 3'b100,
    OP_ROL   = 3'b101,
    OP_ROR   = 3'b110,
    OP_ASR   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // PASS and CLR finish without stepping, so they load a zero count.
  function automatic logic op_is_immediate(input op_e op);
    return (op == OP_PASS) || (op == OP_PASS2) || (op == OP_CLR);
  endfunction

endpackage

// File: rtl/shifter_step.sv
// One-position shift/rotate of a WIDTH-bit word, plus the bit that leaves it.
module shifter_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] y,
  input  op_e              op,
  output logic [WIDTH-1:0] y_next,
  output logic             out_bit
);

  always_comb begin
    y_next  = y;
    out_bit = 1'b0;
    case (op)
      OP_SHL: begin
        y_next  = {y[WIDTH-2:0], 1'b0};
        out_bit = y[WIDTH-1];
      end
      OP_SHR: begin
        y_next  = {1'b0, y[WIDTH-1:1]};
        out_bit = y[0];
      end
      OP_ROL: begin
        y_next  = {y[WIDTH-2:0], y[WIDTH-1]};
        out_bit = y[WIDTH-1];
      end
      OP_ROR: begin
        y_next  = {y[0], y[WIDTH-1:1]};
        out_bit = y[0];
      end
      OP_ASR: begin
        y_next  = {y[WIDTH-1], y[WIDTH-1:1]};
        out_bit = y[0];
      end
      OP_CLR: y_next = '0;
      default: ;
    endcase
  end

endmodule

// File: rtl/shifter_seq.sv
// Multi-cycle shift/rotate unit: one bit position per clock under a start/done handshake.
module shifter_seq
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  input  logic [AMT_W-1:0] amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             zero
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             cout_q, cout_d;
  op_e              op_q, op_d;

  logic [WIDTH-1:0] step_y;
  logic             step_out;

  shifter_step #(.WIDTH(WIDTH)) u_step (
    .y       (y_q),
    .op      (op_q),
    .y_next  (step_y),
    .out_bit (step_out)
  );

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    op_d    = op_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          op_d    = op_e'(op);
          y_d     = (op_e'(op) == OP_CLR) ? '0 : d;
          cnt_d   = op_is_immediate(op_e'(op)) ? '0 : amt;
          cout_d  = 1'b0;
          state_d = SHIFT;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          y_d    = step_y;
          cout_d = step_out;
          cnt_d  = cnt_q - AMT_W'(1);
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      op_q    <= OP_PASS;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      op_q    <= op_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign y    = y_q;
  assign cout = cout_q;
  assign zero = (y_q == '0);

endmodule

// File: tb/tb_shifter_seq.sv
// Self-checking bench for shifter_seq at WIDTH=8: vector table, random vectors and handshake corner cases.
module tb_shifter_seq;

  localparam int W  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  d;
  logic [AW-1:0] amt;
  logic          busy, done, cout, zero;
  logic [W-1:0]  y;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]    op;
    logic [W-1:0]  d;
    logic [AW-1:0] amt;
    logic [W-1:0]  y;
    logic          cout;
    int            lat;
  } vec_t;

  vec_t sb_q[$];
  vec_t vecs[14];

  shifter_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .d     (d),
    .amt   (amt),
    .busy  (busy),
    .done  (done),
    .y     (y),
    .cout  (cout),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference built from whole-word shift operators.
  function automatic void model(input logic [2:0] o, input logic [W-1:0] dv, input int a,
                                output logic [W-1:0] ey, output logic ec, output int lat);
    ey  = dv;
    ec  = 1'b0;
    lat = a + 1;
    case (o)
      3'b000, 3'b100: lat = 1;
      3'b011: begin ey = '0; lat = 1; end
      3'b001: begin ey = dv << a; ec = (a > 0) ? dv[W-a] : 1'b0; end
      3'b010: begin ey = dv >> a; ec = (a > 0) ? dv[a-1] : 1'b0; end
      3'b111: begin ey = $signed(dv) >>> a; ec = (a > 0) ? dv[a-1] : 1'b0; end
      3'b101: begin ey = (dv << a) | (dv >> (W - a)); ec = (a > 0) ? ey[0] : 1'b0; end
      3'b110: begin ey = (dv >> a) | (dv << (W - a)); ec = (a > 0) ? ey[W-1] : 1'b0; end
      default: ;
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [W-1:0] dv, input logic [AW-1:0] a,
                       input logic [W-1:0] ey, input logic ec, input int lat);
    vec_t v;
    v.op = o; v.d = dv; v.amt = a; v.y = ey; v.cout = ec; v.lat = lat;
    sb_q.push_back(v);
    start = 1'b1; op = o; d = dv; amt = a;
    tick();
    start = 1'b0;
    op = 3'($urandom); d = W'($urandom); amt = AW'($urandom);
  endtask

  task automatic wait_done(input int already, input bit chk_pulse);
    int   cyc  = already;
    int   bcnt = already;
    vec_t e;
    while (!done && cyc < 64) begin
      if (busy) bcnt++;
      tick();
      cyc++;
    end
    if (!done) begin
      check("done_timeout", 32'(done), 1);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      return;
    end
    if (sb_q.size() == 0) begin
      check("sb_underflow", 0, 1);
      return;
    end
    e = sb_q.pop_front();
    $display("txn op=%0d d=%02h amt=%0d -> y=%02h cout=%0d zero=%0d lat=%0d busy=%0d (exp y=%02h cout=%0d lat=%0d)",
             e.op, e.d, e.amt, y, cout, zero, cyc, bcnt, e.y, e.cout, e.lat);
    check("y", 32'(y), 32'(e.y));
    check("cout", 32'(cout), 32'(e.cout));
    check("zero", 32'(zero), 32'(e.y == '0));
    check("latency", cyc, e.lat);
    check("busy_cycles", bcnt, e.lat);
    if (chk_pulse) begin
      tick();
      check("done_pulse", 32'(done), 0);
      check("y_held", 32'(y), 32'(e.y));
    end
  endtask

  initial begin
    logic [W-1:0]  ry;
    logic          rc;
    int            rl;
    logic [2:0]    ro;
    logic [W-1:0]  rd;
    logic [AW-1:0] ra;
    bit            saw_done;

    vecs[0]  = '{3'b001, 8'h81, 3'd3, 8'h08, 1'b0, 4};
    vecs[1]  = '{3'b111, 8'h90, 3'd2, 8'hE4, 1'b0, 3};
    vecs[2]  = '{3'b110, 8'h01, 3'd1, 8'h80, 1'b1, 2};
    vecs[3]  = '{3'b101, 8'h80, 3'd7, 8'h40, 1'b0, 8};
    vecs[4]  = '{3'b010, 8'h5A, 3'd0, 8'h5A, 1'b0, 1};
    vecs[5]  = '{3'b011, 8'hFF, 3'd5, 8'h00, 1'b0, 1};
    vecs[6]  = '{3'b000, 8'hA5, 3'd3, 8'hA5, 1'b0, 1};
    vecs[7]  = '{3'b100, 8'h3C, 3'd6, 8'h3C, 1'b0, 1};
    vecs[8]  = '{3'b001, 8'h81, 3'd1, 8'h02, 1'b1, 2};
    vecs[9]  = '{3'b010, 8'h81, 3'd1, 8'h40, 1'b1, 2};
    vecs[10] = '{3'b111, 8'h81, 3'd7, 8'hFF, 1'b0, 8};
    vecs[11] = '{3'b110, 8'h81, 3'd7, 8'h03, 1'b0, 8};
    vecs[12] = '{3'b001, 8'hFF, 3'd7, 8'h80, 1'b1, 8};
    vecs[13] = '{3'b101, 8'h81, 3'd1, 8'h03, 1'b1, 2};

    rst_n = 1'b0; start = 1'b0; op = '0; d = '0; amt = '0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_y", 32'(y), 0);
    check("rst_cout", 32'(cout), 0);
    check("rst_zero", 32'(zero), 1);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].d, vecs[i].amt, vecs[i].y, vecs[i].cout, vecs[i].lat);
      wait_done(0, 1'b1);
    end

    for (int i = 0; i < 10; i++) begin
      ro = 3'($urandom_range(0, 7));
      rd = W'($urandom);
      ra = AW'($urandom_range(0, W - 1));
      model(ro, rd, int'(ra), ry, rc, rl);
      issue(ro, rd, ra, ry, rc, rl);
      wait_done(0, 1'b1);
    end

    // start while busy is ignored, then a start in the DONE cycle is taken back-to-back
    issue(3'b001, 8'h81, 3'd3, 8'h08, 1'b0, 4);
    start = 1'b1; op = 3'b000; d = 8'h0F; amt = 3'd0;
    tick();
    start = 1'b0;
    wait_done(1, 1'b0);
    issue(3'b110, 8'h01, 3'd1, 8'h80, 1'b1, 2);
    check("b2b_busy", 32'(busy), 1);
    wait_done(0, 1'b1);

    // reset mid-SHIFT aborts the operation with no done pulse
    start = 1'b1; op = 3'b001; d = 8'h81; amt = 3'd5;
    tick();
    start = 1'b0;
    tick();
    check("pre_rst_y", 32'(y), 32'h02);
    rst_n = 1'b0;
    tick();
    tick();
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_y", 32'(y), 0);
    check("midrst_cout", 32'(cout), 0);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    check("no_done_after_rst", 32'(saw_done), 0);
    $display("txn reset mid-shift: y=%02h busy=%0d done=%0d", y, busy, done);

    check("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
